wb_interconnect_slave_decode: RTL

//  Slave-side end of the Wishbone B3 shared-bus interconnect. Takes the bus after master

---
 rtl/wb_interconnect_slave_decode.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_interconnect_slave_decode.sv
// wb_interconnect_slave_decode
//   Slave-side end of a Wishbone B3 shared-bus interconnect. The arbitrated master bus is
//   decoded by address window and routed to one of S slaves. The chosen slave is latched
//   at the start of a bus cycle and stays selected until m_cyc_i falls, so burst addresses
//   that wander across a window edge still go to the slave that accepted the first beat.
//   Accesses that hit no window are terminated locally with err.
//
// Optional feature: define WB_DECODE_TIMEOUT_EN to add a watchdog that terminates a stalled
//   access with err after TIMEOUT strobed cycles without a slave response.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   m_adr_i .. m_bte_i       arbitrated master request
//   m_dat_o, m_ack_o,
//   m_err_o, m_rty_o         response returned to the master
//   s_adr_o .. s_bte_o       request broadcast to all slaves (combinational copy)
//   s_cyc_o, s_stb_o         per-slave one-hot cycle/strobe
//   s_dat_i, s_ack_i,
//   s_err_i, s_rty_i         packed per-slave responses, slave k at [k*DW +: DW] / bit k

module wb_interconnect_slave_decode #(
    parameter int unsigned      S       = 2,
    parameter int unsigned      AW      = 32,
    parameter int unsigned      DW      = 32,
    parameter logic [S*AW-1:0]  S_MATCH = '0,
    parameter logic [S*AW-1:0]  S_MASK  = '0,
    parameter int unsigned      TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [AW-1:0]     m_adr_i,
    input  logic [DW-1:0]     m_dat_i,
    input  logic [DW/8-1:0]   m_sel_i,
    input  logic              m_we_i,
    input  logic              m_cyc_i,
    input  logic              m_stb_i,
    input  logic [2:0]        m_cti_i,
    input  logic [1:0]        m_bte_i,
    output logic [DW-1:0]     m_dat_o,
    output logic              m_ack_o,
    output logic              m_err_o,
    output logic              m_rty_o,

    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic [2:0]        s_cti_o,
    output logic [1:0]        s_bte_o,
    output logic [S-1:0]      s_cyc_o,
    output logic [S-1:0]      s_stb_o,
    input  logic [S*DW-1:0]   s_dat_i,
    input  logic [S-1:0]      s_ack_i,
    input  logic [S-1:0]      s_err_i,
    input  logic [S-1:0]      s_rty_i
);

    typedef enum logic [1:0] {StIdle, StActive, StMiss} state_e;

    state_e         state_q;
    logic [S-1:0]   sel_q;

    logic [S-1:0]   hit_onehot;
    logic           hit_any;
    logic [DW-1:0]  sel_dat;
    logic           sel_ack;
    logic           sel_err;
    logic           sel_rty;
    logic           active;
    logic           timeout_hit;

    // Address decode; scanning upward and stopping at the first hit gives the lowest
    // index priority when windows overlap.
    always_comb begin
        hit_onehot = '0;
        hit_any    = 1'b0;
        for (int k = 0; k < S; k++) begin
            if (!hit_any && ((m_adr_i & S_MASK[k*AW +: AW]) == S_MATCH[k*AW +: AW])) begin
                hit_onehot[k] = 1'b1;
                hit_any       = 1'b1;
            end
        end
    end

    // Response mux; sel_q is one-hot or zero, so zero selects nothing and yields zeros.
    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        for (int k = 0; k < S; k++) begin
            if (sel_q[k]) begin
                sel_dat = s_dat_i[k*DW +: DW];
                sel_ack = s_ack_i[k];
                sel_err = s_err_i[k];
                sel_rty = s_rty_i[k];
            end
        end
    end

    assign active = (state_q == StActive);

`ifdef WB_DECODE_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic          cnt_inc;

    assign cnt_inc     = active & m_cyc_i & m_stb_i & ~(sel_ack | sel_err | sel_rty);
    // Fires in the cycle whose increment would bring the count up to TIMEOUT.
    assign timeout_hit = cnt_inc && ((32'(cnt_q) + 32'd1) == TIMEOUT);

    always_ff @(posedge clk_i) begin
        if (rst_i || !cnt_inc || timeout_hit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m_cyc_i && m_stb_i) begin
                        if (hit_any) begin
                            state_q <= StActive;
                            sel_q   <= hit_onehot;
                        end else begin
                            state_q <= StMiss;
                        end
                    end
                end
                StActive: begin
                    if (!m_cyc_i) begin
                        state_q <= StIdle;
                        sel_q   <= '0;
                    end else if (timeout_hit) begin
                        // Drop the stalled slave; the rest of the cycle is answered with err.
                        state_q <= StMiss;
                        sel_q   <= '0;
                    end
                end
                StMiss: begin
                    if (!m_cyc_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    sel_q   <= '0;
                end
            endcase
        end
    end

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;
    assign s_cti_o = m_cti_i;
    assign s_bte_o = m_bte_i;
    assign s_cyc_o = sel_q & {S{m_cyc_i}};
    assign s_stb_o = sel_q & {S{m_stb_i}};

    // Responses are gated by m_cyc_i so an ack arriving after the master gave up is dropped.
    assign m_dat_o = sel_dat;
    assign m_ack_o = active & m_cyc_i & sel_ack;
    assign m_rty_o = active & m_cyc_i & sel_rty;
    assign m_err_o = (active & m_cyc_i & (sel_err | timeout_hit))
                   | ((state_q == StMiss) & m_cyc_i & m_stb_i);

endmodule
